uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit buffering stage that sits directly upstream of `uart_transmission` in the user-project UART.
- Accepts bytes pushed by the Wishbone `ctrl` block into a DEPTH-entry FIFO.
- Drains them one at a time into the transmitter using the existing `tx_data`/`tx_start`/`clear_req`/`busy` handshake.
- Lets firmware queue a burst of bytes without polling `tx_busy` per byte.
- Reports fill status and a transmit-done interrupt pulse back to `ctrl`.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- DATA_W, 8, byte width.

Ports:
- clk  in  1  system clock (wb_clk_i).
- rst_n  in  1  asynchronous, active-low reset.
- i_wr_en  in  1  push strobe from ctrl (single-cycle per byte).
- i_wr_data  in  DATA_W  byte to push.
- i_flush  in  1  synchronous FIFO clear.
- i_ovf_clear  in  1  clears o_overflow.
- o_full  out  1  FIFO full.
- o_empty  out  1  FIFO empty.
- o_level  out  $clog2(DEPTH)+1  entries held.
- o_overflow  out  1  sticky: a push was dropped.
- o_tx_data  out  DATA_W  to uart_transmission tx_data.
- o_tx_start  out  1  to uart_transmission tx_start.
- i_tx_clear  in  1  clear_req pulse from uart_transmission.
- i_tx_busy  in  1  busy from uart_transmission.
- o_done_irq  out  1  one-cycle pulse: last byte finished, FIFO empty.

## Operation
- Storage: circular buffer with write pointer, read pointer, and count.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Count is $clog2(DEPTH)+1 bits.
  - o_full = (count==DEPTH), o_empty = (count==0), o_level = count; all registered.
- Push: i_wr_en && (!o_full || pop this cycle) writes mem[wptr] and increments wptr.
  - i_wr_en && o_full && no pop: byte dropped, o_overflow set.
- Simultaneous push and pop: both take effect, count unchanged.
- o_overflow: cleared by i_ovf_clear. If set and clear occur in the same cycle, set wins.
- i_flush: wptr=rptr=count=0. Overrides a same-cycle push and pop.
  - Does not affect an in-flight byte (FSM state, o_tx_data, o_tx_start unchanged).
- FSM states:
  - IDLE, o_tx_start=0. If !o_empty && !i_tx_busy && !i_flush: latch o_tx_data=mem[rptr], pop (rptr++, count--), go REQ.
  - REQ, o_tx_start=1. Hold o_tx_data stable. On i_tx_clear: go GAP.
  - GAP, o_tx_start=0. Exactly one cycle, then IDLE.
- Transmitter contract: uart_transmission asserts busy no later than the cycle it pulses clear_req. GAP plus the IDLE busy check therefore prevent a double start.
- o_done_irq: pulses for one cycle when i_tx_busy falls (registered busy 1→0) while state==IDLE and o_empty==1.
  - No pulse if bytes remain queued.

## Timing
- Reset values:
  - o_tx_data=0, o_tx_start=0.
  - o_full=0, o_empty=1, o_level=0.
  - o_overflow=0, o_done_irq=0.
  - State IDLE, pointers 0.
- Push at cycle N into an empty FIFO with transmitter idle:
  - N+1: o_empty=0, o_level=1.
  - N+2: o_tx_start=1 and o_tx_data valid; o_level=0, o_empty=1.
- i_tx_clear at cycle M: o_tx_start=0 at M+1. Earliest next start is M+3, and only if i_tx_busy is low.
- Back-to-back bytes: a new start waits for i_tx_busy low. Throughput is limited by the transmitter, never by this block.
- i_tx_clear outside REQ is ignored.
- Reset mid-REQ: o_tx_start drops immediately (asynchronous), FIFO contents are discarded, no o_done_irq.

## Structure
- Shared package `uart_pkg`:
  - tx FSM state enum (IDLE/REQ/GAP).
  - DATA_W default.
  - Helper constant for the level width.
- One sub-module `uart_fifo_ram`: DEPTH×DATA_W register array with a synchronous write port and an asynchronous read port. No reset on data.
- Pointer, count and FSM logic live in uart_tx_fifo.

## Test plan
- Reset, then push 0x41 with busy=0:
  - o_tx_start=1, o_tx_data=0x41 two cycles later.
  - Model pulses clear and holds busy for 10 cycles; o_done_irq pulses once when busy falls.
- Push 0x01..0x08 in 8 consecutive cycles with transmitter stalled (busy=1):
  - o_full=1, o_level=8.
  - 9th push 0x09 is dropped and o_overflow=1.
  - Release transmitter: bytes emerge 0x01..0x08 in order, no 0x09.
- FIFO full plus a push in the same cycle as a pop (IDLE start): push accepted, o_level stays 8, o_overflow stays 0.
- Push 3 bytes with 2 queued and 1 in REQ, then flush:
  - o_level=0 next cycle.
  - The in-flight byte still completes its clear handshake.
  - No further o_tx_start follows.
- Wrap-around: stream 20 bytes with random push gaps and random transmitter latency. Output sequence equals input, pointers wrap cleanly.
- Deassert rst_n while in REQ: o_tx_start=0 and o_empty=1 asynchronously; after release, FSM is in IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: tx handshake FSM states,
// default byte width and the FIFO level-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

  localparam int unsigned DATA_W_DEF = 8;

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $unsigned($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
module uart_fifo_ram #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of uart_transmission: buffers bytes from ctrl and
// feeds them one at a time through the tx_start/clear_req/busy handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_flush,
  input  logic                       i_ovf_clear,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [lvl_w(DEPTH)-1:0]    o_level,
  output logic                       o_overflow,
  output logic [DATA_W-1:0]          o_tx_data,
  output logic                       o_tx_start,
  input  logic                       i_tx_clear,
  input  logic                       i_tx_busy,
  output logic                       o_done_irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = lvl_w(DEPTH);

  logic [PTR_W-1:0]  wptr, rptr;
  logic [LVL_W-1:0]  count, count_nxt;
  logic [DATA_W-1:0] rd_data;
  logic              pop, push, drop;
  logic              busy_q;
  tx_state_t         state, state_nxt;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when the FSM starts a byte at that edge.
  assign pop  = (state == ST_IDLE) && !o_empty && !i_tx_busy && !i_flush;
  assign push = i_wr_en && (!o_full || pop) && !i_flush;
  assign drop = i_wr_en && o_full && !pop;

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (i_wr_data),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_comb begin
    count_nxt = count;
    if (i_flush) begin
      count_nxt = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_nxt = count + LVL_W'(1);
        2'b01:   count_nxt = count - LVL_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (pop) state_nxt = ST_REQ;
      ST_REQ:  if (i_tx_clear) state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (i_flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_W'(1);
        if (pop)  rptr <= rptr + PTR_W'(1);
      end
      count   <= count_nxt;
      o_full  <= (count_nxt == LVL_W'(DEPTH));
      o_empty <= (count_nxt == '0);
    end
  end

  assign o_level = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
    end else if (i_ovf_clear) begin
      o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      busy_q     <= 1'b0;
      o_done_irq <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_tx_start <= (state_nxt == ST_REQ);
      if (pop) o_tx_data <= rd_data;
      busy_q     <= i_tx_busy;
      o_done_irq <= busy_q && !i_tx_busy && (state == ST_IDLE) && o_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a transmitter model and byte scoreboard.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       ovf_clear;
  logic       full, empty, overflow;
  logic [3:0] level;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_clear;
  logic       tx_busy;
  logic       done_irq;

  uart_tx_fifo #(
    .DEPTH  (8),
    .DATA_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (wr_en),
    .i_wr_data   (wr_data),
    .i_flush     (flush),
    .i_ovf_clear (ovf_clear),
    .o_full      (full),
    .o_empty     (empty),
    .o_level     (level),
    .o_overflow  (overflow),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .i_tx_clear  (tx_clear),
    .i_tx_busy   (tx_busy),
    .o_done_irq  (done_irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Transmitter model controls (written by stimulus, read by model)
  bit stall    = 1'b0;
  bit hold     = 1'b0;
  bit rand_lat = 1'b0;
  int lat      = 10;

  logic [7:0] rx_mem [256];
  int rx_n = 0;
  int rx_rd = 0;
  logic [7:0] exp_q [$];

  int start_cnt = 0;
  int irq_cnt = 0;

  // Transmitter model: acts shortly after each rising edge
  initial begin
    int cnt;
    cnt = 0;
    tx_clear = 1'b0;
    tx_busy  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_clear = 1'b0;
      if (!rst_n) begin
        tx_busy = 1'b0;
        cnt = 0;
      end else if (stall) begin
        tx_busy = 1'b1;
        cnt = 0;
      end else if (tx_start && !hold) begin
        rx_mem[rx_n[7:0]] = tx_data;
        rx_n++;
        tx_clear = 1'b1;
        tx_busy  = 1'b1;
        cnt = rand_lat ? int'($urandom_range(1, 6)) : lat;
      end else if (cnt > 1) begin
        cnt--;
      end else begin
        cnt = 0;
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    bit sp;
    sp = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !sp) start_cnt++;
      sp = tx_start;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done_irq) irq_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit to_sb);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    if (to_sb) exp_q.push_back(b);
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int i;
    i = 0;
    while (((rx_n < rx_rd + exp_q.size()) || tx_busy || !empty || tx_start) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(i < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic sb_drain(input string tag);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (rx_rd < rx_n) begin
        check(tag, 32'(rx_mem[rx_rd[7:0]]), 32'(e));
        rx_rd++;
      end else begin
        check({tag, "_missing"}, 32'hFFFF_FFFF, 32'(e));
      end
    end
    check({tag, "_extra"}, rx_n, rx_rd);
  endtask

  initial begin
    int irq_base;
    int sc;
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    flush = 1'b0;
    ovf_clear = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_start",    32'(tx_start), 32'd0);
    check("rst_data",     32'(tx_data),  32'd0);
    check("rst_full",     32'(full),     32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_level",    32'(level),    32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_irq",      32'(done_irq), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);

    // Single byte latency and done interrupt
    push_byte(8'h41, 1'b1);
    check("t1_level_n1", 32'(level), 32'd1);
    check("t1_empty_n1", 32'(empty), 32'd0);
    @(negedge clk);
    check("t1_start_n2", 32'(tx_start), 32'd1);
    check("t1_data_n2",  32'(tx_data),  32'h41);
    check("t1_level_n2", 32'(level),    32'd0);
    check("t1_empty_n2", 32'(empty),    32'd1);
    wait_quiet("t1_timeout", 60);
    check("t1_irq_once", irq_cnt, 1);
    sb_drain("t1_byte");

    // Fill while stalled, overflow, then push during pop when full
    irq_base = irq_cnt;
    stall = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b1);
    check("t2_full",  32'(full),  32'd1);
    check("t2_level", 32'(level), 32'd8);
    check("t2_ovf_before", 32'(overflow), 32'd0);
    push_byte(8'h09, 1'b0);
    check("t2_ovf_set", 32'(overflow), 32'd1);
    check("t2_level_after_drop", 32'(level), 32'd8);
    ovf_clear = 1'b1;
    push_byte(8'h09, 1'b0);
    ovf_clear = 1'b0;
    check("t2_ovf_set_wins", 32'(overflow), 32'd1);
    ovf_clear = 1'b1;
    @(negedge clk);
    ovf_clear = 1'b0;
    check("t2_ovf_cleared", 32'(overflow), 32'd0);
    stall = 1'b0;
    @(negedge clk);
    push_byte(8'h0A, 1'b1);
    check("t3_level_stays", 32'(level),    32'd8);
    check("t3_full_stays",  32'(full),     32'd1);
    check("t3_ovf_stays",   32'(overflow), 32'd0);
    wait_quiet("t2_timeout", 400);
    check("t2_irq_once", irq_cnt, irq_base + 1);
    sb_drain("t2_order");

    // Flush with one byte in flight and two queued
    hold = 1'b1;
    push_byte(8'hA1, 1'b1);
    push_byte(8'hA2, 1'b0);
    push_byte(8'hA3, 1'b0);
    check("t4_level_pre", 32'(level),    32'd2);
    check("t4_start_pre", 32'(tx_start), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t4_level_flush", 32'(level),    32'd0);
    check("t4_empty_flush", 32'(empty),    32'd1);
    check("t4_start_kept",  32'(tx_start), 32'd1);
    check("t4_data_kept",   32'(tx_data),  32'hA1);
    sc = start_cnt;
    hold = 1'b0;
    wait_quiet("t4_timeout", 100);
    repeat (10) @(negedge clk);
    check("t4_no_restart", start_cnt, sc);
    sb_drain("t4_inflight");

    // Wrap-around stream with random gaps and latencies
    rand_lat = 1'b1;
    for (int k = 0; k < 20; k++) begin
      int w;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = 0;
      while (full && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) check("t5_full_stuck", 32'(full), 32'd0);
      push_byte(8'($urandom), 1'b1);
    end
    wait_quiet("t5_timeout", 1000);
    sb_drain("t5_stream");
    rand_lat = 1'b0;

    // Asynchronous reset while a byte is in REQ
    hold = 1'b1;
    push_byte(8'hB1, 1'b0);
    push_byte(8'hB2, 1'b0);
    check("t6_start_pre", 32'(tx_start), 32'd1);
    check("t6_empty_pre", 32'(empty),    32'd0);
    irq_base = irq_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_start_async", 32'(tx_start), 32'd0);
    check("t6_empty_async", 32'(empty),    32'd1);
    check("t6_level_async", 32'(level),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_start_after", 32'(tx_start), 32'd0);
    check("t6_no_irq",      irq_cnt,       irq_base);
    push_byte(8'hC5, 1'b1);
    @(negedge clk);
    check("t6_idle_start", 32'(tx_start), 32'd1);
    check("t6_idle_data",  32'(tx_data),  32'hC5);
    wait_quiet("t6_timeout", 60);
    sb_drain("t6_byte");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
